mem_store_buffer: RTL and testbench

//  Store buffer between the pipeline MEM stage (EX/MEM register outputs) and data memory.

---
 rtl/mem_sb_pkg.sv | 20 ++
 rtl/sb_fifo.sv | 75 +++++++
 rtl/mem_store_buffer.sv | 158 +++++++++++++++
 tb/tb_mem_store_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sb_pkg.sv
// Shared types for the MEM-stage store buffer: FSM state encoding and the
// buffered store entry (word address plus data).
package mem_sb_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_WRITE,
        SB_READ
    } sb_state_t;

    // Only the word address is kept; byte offset bits never take part in a match.
    typedef struct packed {
        logic [SB_AW-1:2] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store buffer storage: circular FIFO of pending stores with a youngest-first
// address match used to forward buffered data to loads.
module sb_fifo
    import mem_sb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  sb_entry_t        push_entry,
    output sb_entry_t        head,
    output logic [PW:0]      count,
    output logic             full,
    input  logic [SB_AW-1:2] lookup_addr,
    output logic             hit,
    output logic [SB_DW-1:0] hit_data
);

    sb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    scan_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            // Clear before set so a full push+pop reuses the head slot correctly.
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                valid[wr_ptr] <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head = mem[rd_ptr];
    assign full = count[PW];

    // Scan from the newest entry (tail-1) back toward the head; first match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            scan_idx = wr_ptr - PW'(i);
            if (!hit && valid[scan_idx] && (mem[scan_idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = mem[scan_idx].data;
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM stage and a req/ack data memory: stores retire
// into a FIFO and drain in the background; loads forward or read memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SB_IDLE  | no memory transaction; picks a load miss first, else a drain
// SB_WRITE | head store in flight; popped on mem_ack
// SB_READ  | load miss in flight; data returned to the pipeline on mem_ack
module mem_store_buffer
    import mem_sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwriteM,
    input  logic          memreadM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] wdataM,
    output logic [DW-1:0] rdataM,
    output logic          stallM,
    output logic          sb_empty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);

    sb_state_t     state;
    sb_state_t     state_nxt;
    sb_entry_t     new_entry;
    sb_entry_t     head;
    logic [PW:0]   count;
    logic          full;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          is_store;
    logic          is_load;
    logic          load_miss;
    logic          req_done;
    logic          wr_done;
    logic          rd_done;
    logic          push;
    logic          pop;
    logic          launch_wr;
    logic          launch_rd;
    logic          addr_lsb_unused;

    // Word accesses only: the byte offset is dropped everywhere.
    assign addr_lsb_unused = ^addrM[1:0];

    // A simultaneous sw/lw is handled as a store.
    assign is_store  = memwriteM;
    assign is_load   = memreadM & ~memwriteM;
    assign load_miss = is_load & ~hit;
    assign req_done  = mem_req & mem_ack;
    assign wr_done   = (state == SB_WRITE) & req_done;
    assign rd_done   = (state == SB_READ) & req_done;
    assign push      = is_store & (~full | wr_done);
    assign pop       = wr_done;
    assign new_entry = '{addr: addrM[AW-1:2], data: wdataM};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry (new_entry),
        .head       (head),
        .count      (count),
        .full       (full),
        .lookup_addr(addrM[AW-1:2]),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch_wr = 1'b0;
        launch_rd = 1'b0;
        unique case (state)
            SB_IDLE: begin
                if (load_miss) begin
                    state_nxt = SB_READ;
                    launch_rd = 1'b1;
                end else if (count != '0) begin
                    state_nxt = SB_WRITE;
                    launch_wr = 1'b1;
                end
            end
            SB_WRITE: begin
                if (wr_done) begin
                    state_nxt = SB_IDLE;
                end
            end
            SB_READ: begin
                if (rd_done) begin
                    state_nxt = SB_IDLE;
                end
            end
            default: state_nxt = SB_IDLE;
        endcase
    end

    // Request fields are registered with the state change and held until ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (launch_rd) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {addrM[AW-1:2], 2'b00};
        end else if (launch_wr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {head.addr, 2'b00};
            mem_wdata <= head.data;
        end else if (req_done) begin
            mem_req <= 1'b0;
        end
    end

    always_comb begin
        stallM = 1'b0;
        rdataM = '0;
        if (is_store) begin
            stallM = ~push;
        end else if (is_load) begin
            if (hit) begin
                rdataM = hit_data;
            end else if (rd_done) begin
                rdataM = mem_rdata;
            end else begin
                stallM = 1'b1;
            end
        end
    end

    assign sb_empty = (count == '0) & (state == SB_IDLE);

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: scoreboarded write drains and load
// results against a req/ack memory model with configurable ack delay.
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic [31:0] rdataM;
    logic        stallM;
    logic        sb_empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .memwriteM(memwriteM),
        .memreadM (memreadM),
        .addrM    (addrM),
        .wdataM   (wdataM),
        .rdataM   (rdataM),
        .stallM   (stallM),
        .sb_empty (sb_empty),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wq [$];
    logic [31:0] exp_rq [$];
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] ref_img [logic [31:0]];

    int n_tests;
    int n_fail;
    int wr_cnt;
    int fix_dly;
    bit auto_ack;
    bit rand_dly;
    bit force_ack;
    bit rd_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input logic [31:0] k);
        return mem_img.exists(k) ? mem_img[k] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] k);
        return ref_img.exists(k) ? ref_img[k] : 32'h0;
    endfunction

    // Memory responder: acks a request once it has been up for dly cycles.
    initial begin
        bit in_req;
        int age;
        int dly;
        in_req    = 1'b0;
        age       = 0;
        dly       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_ack || !mem_req) in_req = 1'b0;
            if (mem_req && !in_req) begin
                in_req = 1'b1;
                age    = 0;
                dly    = rand_dly ? int'($urandom_range(0, 3)) : fix_dly;
            end else if (in_req) begin
                age++;
            end
            mem_ack   = force_ack || (auto_ack && in_req && age >= dly);
            mem_rdata = (mem_req && !mem_we) ? mem_get(mem_addr) : 32'h0;
        end
    end

    // Write monitor: every completed write must be the oldest expected store.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_req) begin
            if (!mem_we) rd_seen = 1'b1;
            if (mem_ack && mem_we) begin
                wr_cnt++;
                mem_img[mem_addr] = mem_wdata;
                if (exp_wq.size() == 0) begin
                    chk("wr_unexpected", 32'(exp_wq.size()), 32'd1);
                end else begin
                    e = exp_wq.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
        end
    end

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
        int  n;
        wr_t e;
        n = 0;
        @(posedge clk); #1;
        memreadM  = 1'b0;
        memwriteM = 1'b1;
        addrM     = a;
        wdataM    = d;
        @(negedge clk);
        while (stallM && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("sw_accept", 32'(stallM), 32'd0);
        if (!stallM) begin
            e.a = {a[31:2], 2'b00};
            e.d = d;
            exp_wq.push_back(e);
            ref_img[e.a] = d;
        end
        @(posedge clk); #1;
        memwriteM = 1'b0;
    endtask

    task automatic do_lw(input logic [31:0] a, input logic [31:0] exp, input string tag,
                         output int stalls);
        int          n;
        logic [31:0] e;
        n = 0;
        exp_rq.push_back(exp);
        @(posedge clk); #1;
        memwriteM = 1'b0;
        memreadM  = 1'b1;
        addrM     = a;
        @(negedge clk);
        while (stallM && n < 40) begin
            @(negedge clk);
            n++;
        end
        stalls = n;
        chk({tag, "_done"}, 32'(stallM), 32'd0);
        e = exp_rq.pop_front();
        if (!stallM) chk(tag, rdataM, e);
        @(posedge clk); #1;
        memreadM = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (!(mem_req && mem_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack"}, 32'(mem_req && mem_ack), 32'd1);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!sb_empty && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drained"}, 32'(sb_empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls;
        int          base;
        int          n;
        logic [31:0] a;
        logic [31:0] d;
        wr_t         e;

        n_tests   = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        fix_dly   = 0;
        auto_ack  = 1'b1;
        rand_dly  = 1'b0;
        force_ack = 1'b0;
        rd_seen   = 1'b0;
        reset     = 1'b1;
        memwriteM = 1'b0;
        memreadM  = 1'b0;
        addrM     = '0;
        wdataM    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_mem_req",   32'(mem_req),  32'd0);
        chk("rst_mem_we",    32'(mem_we),   32'd0);
        chk("rst_mem_addr",  mem_addr,      32'h0);
        chk("rst_mem_wdata", mem_wdata,     32'h0);
        chk("rst_stallM",    32'(stallM),   32'd0);
        chk("rst_sb_empty",  32'(sb_empty), 32'd1);
        chk("rst_rdataM",    rdataM,        32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of a write
        auto_ack = 1'b0;
        do_sw(32'h80, 32'h1234_5678);
        wait_req("t1");
        chk("t1_empty_busy", 32'(sb_empty), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t1_rst_req",   32'(mem_req),  32'd0);
        chk("t1_rst_stall", 32'(stallM),   32'd0);
        chk("t1_rst_empty", 32'(sb_empty), 32'd1);
        exp_wq.delete();
        @(posedge clk); #1;
        reset    = 1'b0;
        auto_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_no_resume_req", 32'(mem_req),  32'd0);
        chk("t1_still_empty",   32'(sb_empty), 32'd1);

        // Single drain with ack two cycles after req
        fix_dly = 2;
        do_sw(32'h10, 32'hAAAA_5555);
        wait_req("t2");
        chk("t2_we",    32'(mem_we), 32'd1);
        chk("t2_addr",  mem_addr,    32'h10);
        chk("t2_wdata", mem_wdata,   32'hAAAA_5555);
        wait_ack("t2");
        chk("t2_empty_at_ack", 32'(sb_empty), 32'd0);
        @(negedge clk);
        chk("t2_empty_after", 32'(sb_empty), 32'd1);

        // Forwarding from the youngest match, no memory read
        auto_ack = 1'b0;
        fix_dly  = 0;
        rd_seen  = 1'b0;
        do_sw(32'h20, 32'h1);
        do_sw(32'h20, 32'h2);
        do_lw(32'h20, 32'h2, "t3_fwd", stalls);
        chk("t3_fwd_stalls", 32'(stalls), 32'd0);
        do_lw(32'h22, 32'h2, "t3_fwd_lsb", stalls);
        chk("t3_lsb_stalls", 32'(stalls), 32'd0);
        chk("t3_no_read", 32'(rd_seen), 32'd0);
        auto_ack = 1'b1;
        wait_empty("t3");

        // Full buffer: stall, then accept on the ack that frees a slot
        auto_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            do_sw(32'h200 + 32'(4 * i), 32'h4000 + 32'(i));
        end
        @(posedge clk); #1;
        memwriteM = 1'b1;
        addrM     = 32'h210;
        wdataM    = 32'h4004;
        @(negedge clk);
        chk("t4_full_stall", 32'(stallM), 32'd1);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        chk("t4_accept_on_ack", 32'(stallM), 32'd0);
        if (!stallM) begin
            e.a = 32'h210;
            e.d = 32'h4004;
            exp_wq.push_back(e);
        end
        @(posedge clk); #1;
        force_ack = 1'b0;
        addrM     = 32'h214;
        wdataM    = 32'h4005;
        @(negedge clk);
        chk("t4_still_full", 32'(stallM), 32'd1);
        @(posedge clk); #1;
        auto_ack = 1'b1;
        fix_dly  = 1;
        n = 0;
        @(negedge clk);
        while (stallM && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_sw6_accept", 32'(stallM), 32'd0);
        if (!stallM) begin
            e.a = 32'h214;
            e.d = 32'h4005;
            exp_wq.push_back(e);
        end
        @(posedge clk); #1;
        memwriteM = 1'b0;
        wait_empty("t4");

        // Load miss wins over pending drains; ack on the first req cycle
        auto_ack = 1'b0;
        fix_dly  = 0;
        mem_img[32'h40] = 32'hDEAD_BEEF;
        do_sw(32'h50, 32'h5);
        do_sw(32'h54, 32'h6);
        do_sw(32'h58, 32'h7);
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        force_ack = 1'b0;
        auto_ack  = 1'b1;
        memreadM  = 1'b1;
        addrM     = 32'h40;
        exp_rq.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("t5_stall_first", 32'(stallM), 32'd1);
        @(negedge clk);
        chk("t5_stall_second", 32'(stallM), 32'd0);
        chk("t5_read_we",   32'(mem_we), 32'd0);
        chk("t5_read_addr", mem_addr,    32'h40);
        chk("t5_rdata",     rdataM,      exp_rq.pop_front());
        @(posedge clk); #1;
        memreadM = 1'b0;
        @(negedge clk);
        chk("t5_rdata_idle", rdataM, 32'h0);
        wait_empty("t5");

        // Pointer wrap with random ack delays and interleaved loads
        rand_dly = 1'b1;
        base     = wr_cnt;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            a = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            d = $urandom;
            do_sw(a, d);
            if ($urandom_range(0, 1) == 1) begin
                a = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
                do_lw(a, ref_get({a[31:2], 2'b00}), "t6_lw", stalls);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_empty("t6");
        chk("t6_write_count", 32'(wr_cnt - base), 32'(3 * DEPTH));
        chk("t6_queue_left",  32'(exp_wq.size()), 32'd0);
        for (int k = 0; k < 8; k++) begin
            a = 32'h100 + 32'(4 * k);
            chk("t6_image", mem_get(a), ref_get(a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
